// File: rtl/gate_bist_pkg.sv
// Shared definitions for the 2-input gate BIST engine.
//   state_e : sweep controller states
//   TT_*    : expected truth tables, bit i = output for {a,b} = i
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist.sv
// Built-in self-test engine for a 2-input gate in the clk domain.
// On start, sweeps {a,b} = 00,01,10,11 into the gate, waits SETTLE_CYCLES
// per vector, samples dut_y and compares it with TRUTH_TABLE.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a sweep (only honoured in IDLE)
//   dut_a, dut_b       registered gate inputs (vec[1], vec[0])
//   dut_y              gate output
//   busy               high while a sweep is in progress (through FINISH)
//   done               one-cycle pulse at the end of a sweep
//   pass               1 = last sweep had no mismatches
//   fail_mask          bit i set = vector i mismatched
//   fail_count         number of mismatched vectors, 0..4
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE   = TT_NOR,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] fail_count
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_bist: SETTLE_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       count_q, count_d;
    logic             mismatch;

    assign mismatch = (dut_y != TRUTH_TABLE[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d   = 2'd0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = 4'b0000;
                    count_d = 3'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    mask_d[vec_q] = 1'b1;
                    count_d       = count_q + 3'd1;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    // mask_d already includes the vector-3 result
                    pass_d  = (mask_d == 4'b0000);
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            mask_q  <= 4'b0000;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    assign dut_a      = vec_q[1];
    assign dut_b      = vec_q[0];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_count = count_q;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: one instance with the default settle time
// driven by a selectable gate model, one with SETTLE_CYCLES=1 driven by NOR.
module tb_gate_bist;
    import gate_bist_pkg::*;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic [2:0] count;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2, start1;
    logic [1:0] sel;
    logic       a2, b2, y2, busy2, done2, pass2;
    logic [3:0] mask2;
    logic [2:0] cnt2;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [2:0] cnt1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q2[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 = NOR gate, 1 = output stuck at 0, 2 = XOR gate
    function automatic logic gate_out(input logic [1:0] s, input logic [1:0] ab);
        case (s)
            2'd0:    gate_out = ~(ab[1] | ab[0]);
            2'd2:    gate_out = ab[1] ^ ab[0];
            default: gate_out = 1'b0;
        endcase
    endfunction

    always_comb y2 = gate_out(sel, {a2, b2});
    assign y1 = ~(a1 | b1);

    gate_bist #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(mask2), .fail_count(cnt2)
    );

    gate_bist #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .fail_count(cnt1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected result of a sweep of gate `s` against truth table `tt`
    function automatic exp_t model(input logic [1:0] s, input logic [3:0] tt, input int done_cyc);
        exp_t e;
        e.mask  = 4'b0000;
        e.count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (gate_out(s, 2'(i)) != tt[i]) begin
                e.mask[i] = 1'b1;
                e.count   = e.count + 3'd1;
            end
        end
        e.pass = (e.mask == 4'b0000);
        e.cyc  = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done2) begin
            chk("done2_expected", int'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                exp_t e;
                e = q2.pop_front();
                chk("done2_cycle", cyc, e.cyc);
                chk("pass2", int'(pass2), int'(e.pass));
                chk("mask2", int'(mask2), int'(e.mask));
                chk("count2", int'(cnt2), int'(e.count));
            end
        end
        if (done1) begin
            chk("done1_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("done1_cycle", cyc, e.cyc);
                chk("pass1", int'(pass1), int'(e.pass));
                chk("mask1", int'(mask1), int'(e.mask));
                chk("count1", int'(cnt1), int'(e.count));
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q2.size() + q1.size()) > 0; i++) @(negedge clk);
        chk("drain_pending", int'(q2.size() + q1.size()), 0);
        @(negedge clk);
    endtask

    task automatic sweep2(input logic [1:0] s);
        int c;
        sel = s;
        c = cyc;
        start2 = 1'b1;
        q2.push_back(model(s, TT_NOR, c + 13));
        @(negedge clk);
        start2 = 1'b0;
        drain();
    endtask

    task automatic chk_reset2(input string tag);
        chk({tag, "_busy"}, int'(busy2), 0);
        chk({tag, "_done"}, int'(done2), 0);
        chk({tag, "_pass"}, int'(pass2), 0);
        chk({tag, "_mask"}, int'(mask2), 0);
        chk({tag, "_count"}, int'(cnt2), 0);
        chk({tag, "_ab"}, int'({a2, b2}), 0);
    endtask

    initial begin
        int c;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset2("rst");
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;
        @(negedge clk);

        // correct NOR gate, vector stepping observed at each sample cycle
        sel = 2'd0;
        c = cyc;
        start2 = 1'b1;
        q2.push_back(model(2'd0, TT_NOR, c + 13));
        @(negedge clk);
        start2 = 1'b0;
        chk("busy_after_accept", int'(busy2), 1);
        for (int k = 0; k < 4; k++) begin
            wait_to(c + 3 * (k + 1));
            chk($sformatf("vec%0d", k), int'({a2, b2}), k);
        end
        drain();

        sweep2(2'd1);   // output stuck at 0
        sweep2(2'd2);   // XOR against NOR table

        // start held high on the S=1 instance: second sweep starts after done
        c = cyc;
        start1 = 1'b1;
        q1.push_back(model(2'd0, TT_NOR, c + 9));
        q1.push_back(model(2'd0, TT_NOR, c + 19));
        wait_to(c + 10);
        chk("held_idle_gap", int'(busy1), 0);
        @(negedge clk);
        chk("held_restart", int'(busy1), 1);
        start1 = 1'b0;
        drain();

        // reset mid-sweep: no done, everything back to reset values
        sel = 2'd0;
        c = cyc;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_to(c + 6);
        chk("pre_rst_busy", int'(busy2), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset2("abort");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        sweep2(2'd0);

        // failing sweep, then start accepted the cycle after done
        sel = 2'd1;
        c = cyc;
        start2 = 1'b1;
        q2.push_back(model(2'd1, TT_NOR, c + 13));
        @(negedge clk);
        start2 = 1'b0;
        wait_to(c + 13);
        sel = 2'd0;
        start2 = 1'b1;   // high in FINISH (ignored) and the following IDLE cycle
        q2.push_back(model(2'd0, TT_NOR, c + 27));
        @(negedge clk);
        @(negedge clk);
        start2 = 1'b0;
        chk("b2b_mask_cleared", int'(mask2), 0);
        chk("b2b_count_cleared", int'(cnt2), 0);
        chk("b2b_busy", int'(busy2), 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
